barrel_shift_pipe: RTL and testbench
====================================

Name: barrel_shift_pipe

Overview:
Parametrised, pipelined barrel shifter/rotator with run-time shift amount, direction and mode.
- Shifts data by 0..DATA_WIDTH positions, left or right, in logical, arithmetic or rotate mode.
- Uses a valid/ready stream interface and carries a user tag alongside each word.
- Drops into datapaths that need variable shifts at full throughput (normalisation, field extraction, scrambling).

Parameters:
- DATA_WIDTH, 32: data word width; must be a power of two, >= 2.
- TAG_W, 4: width of the sideband tag carried with each word; >= 1.
- PIPELINE, 1: 1 = one register per log2 stage (latency SHIFT_W); 0 = all stages combinational plus one output register (latency 1).
- SHIFT_W (local), clog2(DATA_WIDTH): number of log2 shift stages.
- AMT_W (local), SHIFT_W+1: shift-amount width, so that DATA_WIDTH itself is encodable.

Ports:
- clk, in, 1: single clock, all logic on rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: input word present.
- in_ready, out, 1: block can accept input this cycle.
- in_data, in, DATA_WIDTH: word to shift.
- in_amt, in, AMT_W: shift amount, unsigned.
- in_dir, in, 1: 1 = right, 0 = left.
- in_mode, in, 2: 00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical).
- in_tag, in, TAG_W: sideband tag, passed through unchanged.
- out_valid, out, 1: result present.
- out_ready, in, 1: downstream accepts result.
- out_data, out, DATA_WIDTH: shifted result.
- out_tag, out, TAG_W: tag of the same transaction.
- out_zero, out, 1: out_data == 0.

Behaviour:
- Reset: all stage valid bits cleared. out_valid=0, out_data=0, out_tag=0, out_zero=1. in_ready=1 in the cycle after rst deasserts.
- Reset mid-operation: all in-flight words are discarded and never emitted.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Pipeline control: global stall, advance = ~out_valid | out_ready. in_ready = advance.
  - On stall, every stage holds its contents.
  - Bubbles do not compress while stalled.
- Throughput: one word per cycle when out_ready=1.
- Latency: SHIFT_W cycles from input transfer to out_valid when PIPELINE=1; 1 cycle when PIPELINE=0.
- Outputs are registered; no combinational path from in_* to out_*.
- Stage k (0..SHIFT_W-1) shifts by 2^k when amt[k]=1. Fill bits per mode:
  - Logical: fills with 0.
  - Arithmetic right: fills with the original in_data MSB, captured at input and carried through the pipeline.
  - Arithmetic left: identical to logical left.
  - Rotate: fills with the bits shifted out, in either direction.
- Amount bit amt[SHIFT_W] (amount >= DATA_WIDTH):
  - Logical: result all zeros.
  - Arithmetic right: result all copies of the sign bit.
  - Rotate: bit ignored, i.e. amount taken modulo DATA_WIDTH.
- Amount 0: data passes unchanged in every mode and direction.
- in_dir, in_mode, the overflow bit and in_tag are captured with the data at input transfer and travel with it. Changes on later cycles never affect in-flight words.
- Values on in_* while in_valid=0 are ignored.
- Stage registers are only enabled when valid, to save power.
- out_zero is registered alongside out_data and is valid whenever out_valid=1.

Decomposition:
- Package barrel_shift_pkg:
  - Mode encodings MODE_LOGICAL=2'b00, MODE_ARITH=2'b01, MODE_ROTATE=2'b10.
  - clog2 function.
  - Stage payload struct: data, remaining amt bits, dir, mode, sign, ovf, tag.
- Sub-module barrel_shift_stage:
  - One log2 stage, parametrised by stage index k and register enable.
  - Instantiated SHIFT_W times via generate.
  - Top-level owns valid/stall control, overflow handling and the output register.

Test Plan (DATA_WIDTH=8, PIPELINE=1, so latency is 3):
1. Mode coverage:
   - in_data=0xB4, amt=2, right, logical -> out_data=0x2D, 3 cycles after accept.
   - Same word, arithmetic -> 0xED.
   - in_data=0xB4, amt=3, left, rotate -> 0xA5.
2. Amount boundaries:
   - 0x80, amt=8, right, arithmetic -> 0xFF.
   - 0xB4, amt=9, left, logical -> 0x00 with out_zero=1.
   - 0xB4, amt=9, right, rotate -> 0x5A.
   - Any data with amt=0 -> unchanged.
3. Streaming: 16 back-to-back words with tags 0..15 and random amt/dir/mode, out_ready=1 -> one result per cycle, in order, tags match, matches reference model.
4. Backpressure:
   - Hold out_ready=0 while streaming -> in_ready drops once the first word reaches output; no word is lost or duplicated.
   - Random out_ready toggling over 1000 words -> scoreboard clean.
5. Reset mid-stream: assert rst for 1 cycle with 3 words in flight -> out_valid=0 the next cycle, none of the 3 words appear, new words after reset are correct.
6. PIPELINE=0 build: repeat scenarios 1 and 3 -> latency exactly 1 cycle, identical results.

Source files
------------

// File: rtl/barrel_shift_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   mode_e        : shift mode encoding (reserved code behaves as logical)
//   clog2         : constant-evaluable ceiling log2 for parameter math
//   stage_ctrl_t  : per-word control fields that travel with the data
// Data, tag and remaining amount ride alongside stage_ctrl_t as separate
// vectors because their widths depend on module parameters.
package barrel_shift_pkg;

    typedef enum logic [1:0] {
        MODE_LOGICAL = 2'b00,
        MODE_ARITH   = 2'b01,
        MODE_ROTATE  = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    function automatic int clog2(input int value);
        int result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    typedef struct packed {
        logic  dir;   // 1 = right
        mode_e mode;  // normalised at capture: never MODE_RSVD in flight
        logic  sign;  // input MSB, used as fill for arithmetic right
        logic  ovf;   // amount >= DATA_WIDTH
    } stage_ctrl_t;

endpackage

// File: rtl/barrel_shift_stage.sv
// One log2 stage of the barrel shifter: shifts by 2^K when amt[K] is set,
// with fill chosen by mode and direction. REG=1 places a register behind
// the shift (valid bit reset, payload loaded only for valid words);
// REG=0 makes the stage purely combinational.
// Ports:
//   clk, rst, advance            : clock, sync reset, global pipeline enable
//   src_valid/data/amt/tag/ctrl  : word entering the stage
//   dst_valid/data/amt/tag/ctrl  : word leaving the stage
module barrel_shift_stage
    import barrel_shift_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_W      = 4,
    parameter int SHIFT_W    = 5,
    parameter int K          = 0,
    parameter bit REG        = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic [SHIFT_W-1:0]    src_amt,
    input  logic [TAG_W-1:0]      src_tag,
    input  stage_ctrl_t           src_ctrl,
    output logic                  dst_valid,
    output logic [DATA_WIDTH-1:0] dst_data,
    output logic [SHIFT_W-1:0]    dst_amt,
    output logic [TAG_W-1:0]      dst_tag,
    output stage_ctrl_t           dst_ctrl
);

    localparam int S = 1 << K;

    logic [DATA_WIDTH-1:0] shl;
    logic [DATA_WIDTH-1:0] shr;
    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        shl = src_data << S;
        shr = src_data >> S;
        if (src_ctrl.mode == MODE_ROTATE) begin
            // bits pushed out of one end re-enter at the other
            shl = shl | (src_data >> (DATA_WIDTH - S));
            shr = shr | (src_data << (DATA_WIDTH - S));
        end else if (src_ctrl.mode == MODE_ARITH && src_ctrl.sign) begin
            // arithmetic left is plain logical left; only right needs sign fill
            shr = shr | ~({DATA_WIDTH{1'b1}} >> S);
        end
        if (src_amt[K]) begin
            shifted = src_ctrl.dir ? shr : shl;
        end else begin
            shifted = src_data;
        end
    end

    if (REG) begin : g_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                dst_valid <= 1'b0;
            end else if (advance) begin
                dst_valid <= src_valid;
            end
        end

        always_ff @(posedge clk) begin
            if (advance && src_valid) begin
                dst_data <= shifted;
                dst_amt  <= src_amt;
                dst_tag  <= src_tag;
                dst_ctrl <= src_ctrl;
            end
        end
    end else begin : g_comb
        logic unused_ctl;
        assign unused_ctl = clk ^ rst ^ advance;
        assign dst_valid  = src_valid;
        assign dst_data   = shifted;
        assign dst_amt    = src_amt;
        assign dst_tag    = src_tag;
        assign dst_ctrl   = src_ctrl;
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter/rotator with valid/ready handshake and a tag
// carried alongside each word.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake
//   in_data, in_amt   : word and unsigned shift amount (0..2^AMT_W-1)
//   in_dir, in_mode   : 1 = right; 00 logical, 01 arith, 10 rotate, 11 logical
//   in_tag            : sideband tag
//   out_valid/out_ready, out_data, out_tag, out_zero : registered result
// The last log2 stage is always combinational into the output register, so
// PIPELINE=1 gives SHIFT_W registers in the path and PIPELINE=0 gives one.
module barrel_shift_pipe
    import barrel_shift_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  TAG_W      = 4,
    parameter int  PIPELINE   = 1,
    localparam int SHIFT_W    = clog2(DATA_WIDTH),
    localparam int AMT_W      = SHIFT_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0]      in_amt,
    input  logic                  in_dir,
    input  logic [1:0]            in_mode,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_zero
);

    logic        advance;
    stage_ctrl_t in_ctrl;

    // Global stall: the whole pipe moves together or not at all.
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    always_comb begin
        in_ctrl.dir  = in_dir;
        in_ctrl.mode = MODE_LOGICAL;
        if (in_mode == 2'b01) in_ctrl.mode = MODE_ARITH;
        if (in_mode == 2'b10) in_ctrl.mode = MODE_ROTATE;
        in_ctrl.sign = in_data[DATA_WIDTH-1];
        in_ctrl.ovf  = in_amt[SHIFT_W];
    end

    for (genvar k = 0; k < SHIFT_W; k++) begin : g_stage
        logic                  src_valid;
        logic [DATA_WIDTH-1:0] src_data;
        logic [SHIFT_W-1:0]    src_amt;
        logic [TAG_W-1:0]      src_tag;
        stage_ctrl_t           src_ctrl;
        logic                  dst_valid;
        logic [DATA_WIDTH-1:0] dst_data;
        logic [SHIFT_W-1:0]    dst_amt;
        logic [TAG_W-1:0]      dst_tag;
        stage_ctrl_t           dst_ctrl;

        if (k == 0) begin : g_src
            assign src_valid = in_valid;
            assign src_data  = in_data;
            assign src_amt   = in_amt[SHIFT_W-1:0];
            assign src_tag   = in_tag;
            assign src_ctrl  = in_ctrl;
        end else begin : g_src
            assign src_valid = g_stage[k-1].dst_valid;
            assign src_data  = g_stage[k-1].dst_data;
            assign src_amt   = g_stage[k-1].dst_amt;
            assign src_tag   = g_stage[k-1].dst_tag;
            assign src_ctrl  = g_stage[k-1].dst_ctrl;
        end

        barrel_shift_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .TAG_W      (TAG_W),
            .SHIFT_W    (SHIFT_W),
            .K          (k),
            .REG        ((PIPELINE != 0) && (k < SHIFT_W - 1))
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .advance   (advance),
            .src_valid (src_valid),
            .src_data  (src_data),
            .src_amt   (src_amt),
            .src_tag   (src_tag),
            .src_ctrl  (src_ctrl),
            .dst_valid (dst_valid),
            .dst_data  (dst_data),
            .dst_amt   (dst_amt),
            .dst_tag   (dst_tag),
            .dst_ctrl  (dst_ctrl)
        );
    end

    logic                  last_valid;
    logic [DATA_WIDTH-1:0] last_data;
    logic [TAG_W-1:0]      last_tag;
    stage_ctrl_t           last_ctrl;
    logic [SHIFT_W-1:0]    unused_amt;
    logic [DATA_WIDTH-1:0] result;

    assign last_valid = g_stage[SHIFT_W-1].dst_valid;
    assign last_data  = g_stage[SHIFT_W-1].dst_data;
    assign last_tag   = g_stage[SHIFT_W-1].dst_tag;
    assign last_ctrl  = g_stage[SHIFT_W-1].dst_ctrl;
    assign unused_amt = g_stage[SHIFT_W-1].dst_amt;

    // Amounts >= DATA_WIDTH: rotate wraps (bit ignored), everything else
    // saturates to all-fill.
    always_comb begin
        result = last_data;
        if (last_ctrl.ovf && last_ctrl.mode != MODE_ROTATE) begin
            if (last_ctrl.mode == MODE_ARITH && last_ctrl.dir) begin
                result = {DATA_WIDTH{last_ctrl.sign}};
            end else begin
                result = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_zero  <= 1'b1;
        end else if (advance) begin
            out_valid <= last_valid;
            if (last_valid) begin
                out_data <= result;
                out_tag  <= last_tag;
                out_zero <= (result == '0);
            end
        end
    end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
module tb_barrel_shift_pipe;
    import barrel_shift_pkg::*;

    localparam int W  = 8;
    localparam int TW = 4;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic [AW-1:0] in_amt = '0;
    logic          in_dir = 1'b0;
    logic [1:0]    in_mode = '0;
    logic [TW-1:0] in_tag = '0;
    logic          rdy = 1'b1;

    logic          in_ready1, out_valid1, out_zero1;
    logic [W-1:0]  out_data1;
    logic [TW-1:0] out_tag1;
    logic          in_ready0, out_valid0, out_zero0;
    logic [W-1:0]  out_data0;
    logic [TW-1:0] out_tag0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    barrel_shift_pipe #(.DATA_WIDTH(W), .TAG_W(TW), .PIPELINE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir), .in_mode(in_mode),
        .in_tag(in_tag), .out_valid(out_valid1), .out_ready(rdy),
        .out_data(out_data1), .out_tag(out_tag1), .out_zero(out_zero1)
    );

    barrel_shift_pipe #(.DATA_WIDTH(W), .TAG_W(TW), .PIPELINE(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir), .in_mode(in_mode),
        .in_tag(in_tag), .out_valid(out_valid0), .out_ready(rdy),
        .out_data(out_data0), .out_tag(out_tag0), .out_zero(out_zero0)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [AW-1:0] amt,
                                               input logic dir, input logic [1:0] mode);
        logic [2*W-1:0]      dd;
        logic signed [W-1:0] sd;
        int                  n;
        n = int'(amt);
        if (mode == 2'b10) begin
            n = n % W;
            if (dir) begin
                dd = {d, d} >> n;
                return dd[W-1:0];
            end
            dd = {d, d} << n;
            return dd[2*W-1:W];
        end
        if (mode == 2'b01 && dir) begin
            if (n >= W) return {W{d[W-1]}};
            sd = d;
            return sd >>> n;
        end
        if (n >= W) return '0;
        return dir ? (d >> n) : (d << n);
    endfunction

    typedef struct packed {
        logic [W-1:0]  d;
        logic [TW-1:0] t;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];
    exp_t e1, e0;

    // Scoreboards: each DUT is tracked against its own handshakes.
    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
            q0.delete();
        end else begin
            if (out_valid1 && rdy) begin
                if (q1.size() == 0) begin
                    chk_eq("p1_unexpected_out", 32'(out_valid1), 32'd0);
                end else begin
                    e1 = q1.pop_front();
                    chk_eq("p1_data", 32'(out_data1), 32'(e1.d));
                    chk_eq("p1_tag", 32'(out_tag1), 32'(e1.t));
                    chk_eq("p1_zero", 32'(out_zero1), 32'(e1.d == '0));
                end
            end
            if (out_valid0 && rdy) begin
                if (q0.size() == 0) begin
                    chk_eq("p0_unexpected_out", 32'(out_valid0), 32'd0);
                end else begin
                    e0 = q0.pop_front();
                    chk_eq("p0_data", 32'(out_data0), 32'(e0.d));
                    chk_eq("p0_tag", 32'(out_tag0), 32'(e0.t));
                    chk_eq("p0_zero", 32'(out_zero0), 32'(e0.d == '0));
                end
            end
            if (in_valid && in_ready1)
                q1.push_back('{ref_shift(in_data, in_amt, in_dir, in_mode), in_tag});
            if (in_valid && in_ready0)
                q0.push_back('{ref_shift(in_data, in_amt, in_dir, in_mode), in_tag});
        end
    end

    // Single word, idle pipe: checks exact latency of both builds.
    task automatic run_vec(input logic [W-1:0] d, input logic [AW-1:0] a, input logic dir,
                           input logic [1:0] m, input logic [TW-1:0] t, input logic [W-1:0] exp);
        int            lat0, lat1;
        logic [W-1:0]  got0, got1;
        logic          z0, z1;
        logic [TW-1:0] tg0, tg1;
        rdy = 1'b1;
        in_valid = 1'b1; in_data = d; in_amt = a; in_dir = dir; in_mode = m; in_tag = t;
        #1;
        chk_eq("vec_in_ready", 32'(in_ready1), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = ~d; in_amt = ~a; in_dir = ~dir; in_tag = ~t;
        lat0 = 0; lat1 = 0;
        got0 = 'x; got1 = 'x; z0 = 1'bx; z1 = 1'bx; tg0 = 'x; tg1 = 'x;
        for (int c = 1; c <= 8; c++) begin
            if (lat0 == 0 && out_valid0) begin
                lat0 = c; got0 = out_data0; z0 = out_zero0; tg0 = out_tag0;
            end
            if (lat1 == 0 && out_valid1) begin
                lat1 = c; got1 = out_data1; z1 = out_zero1; tg1 = out_tag1;
            end
            @(posedge clk); #1;
        end
        chk_eq("vec_lat_p1", 32'(lat1), 32'd3);
        chk_eq("vec_lat_p0", 32'(lat0), 32'd1);
        chk_eq("vec_data_p1", 32'(got1), 32'(exp));
        chk_eq("vec_data_p0", 32'(got0), 32'(exp));
        chk_eq("vec_zero_p1", 32'(z1), 32'(exp == '0));
        chk_eq("vec_zero_p0", 32'(z0), 32'(exp == '0));
        chk_eq("vec_tag_p1", 32'(tg1), 32'(t));
        chk_eq("vec_tag_p0", 32'(tg0), 32'(t));
    endtask

    // Presents one word until u_dut1 takes it; optional random out_ready.
    task automatic send(input logic [W-1:0] d, input logic [AW-1:0] a, input logic dir,
                        input logic [1:0] m, input logic [TW-1:0] t, input bit rnd_rdy);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1; in_data = d; in_amt = a; in_dir = dir; in_mode = m; in_tag = t;
        for (int c = 0; c < 200 && !acc; c++) begin
            if (rnd_rdy) rdy = ($urandom_range(0, 99) < 60);
            #1;
            acc = in_ready1;
            @(posedge clk); #1;
        end
        if (!acc) chk_eq("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic gap(input bit rnd_rdy);
        in_valid = 1'b0;
        in_data = W'($urandom); in_amt = AW'($urandom); in_tag = TW'($urandom);
        in_dir = 1'($urandom); in_mode = 2'($urandom);
        if (rnd_rdy) rdy = ($urandom_range(0, 99) < 60);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int c;
        in_valid = 1'b0;
        rdy = 1'b1;
        c = 0;
        while ((q1.size() != 0 || q0.size() != 0 || out_valid1 || out_valid0) && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk_eq("drain_p1_empty", 32'(q1.size()), 32'd0);
        chk_eq("drain_p0_empty", 32'(q0.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_acc;
        time  t0;
        logic acc;

        // reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_eq("rst_out_valid", 32'(out_valid1), 32'd0);
        chk_eq("rst_out_data", 32'(out_data1), 32'd0);
        chk_eq("rst_out_tag", 32'(out_tag1), 32'd0);
        chk_eq("rst_out_zero", 32'(out_zero1), 32'd1);
        chk_eq("rst_in_ready", 32'(in_ready1), 32'd1);
        chk_eq("rst_out_valid_p0", 32'(out_valid0), 32'd0);

        // directed vectors, hand-computed results
        run_vec(8'hB4, 4'd2, 1'b1, 2'b00, 4'h1, 8'h2D);
        run_vec(8'hB4, 4'd2, 1'b1, 2'b01, 4'h2, 8'hED);
        run_vec(8'hB4, 4'd3, 1'b0, 2'b10, 4'h3, 8'hA5);
        run_vec(8'h80, 4'd8, 1'b1, 2'b01, 4'h4, 8'hFF);
        run_vec(8'hB4, 4'd9, 1'b0, 2'b00, 4'h5, 8'h00);
        run_vec(8'hB4, 4'd9, 1'b1, 2'b10, 4'h6, 8'h5A);
        run_vec(8'h5C, 4'd0, 1'b1, 2'b01, 4'h7, 8'h5C);
        run_vec(8'h5C, 4'd0, 1'b0, 2'b10, 4'h8, 8'h5C);
        run_vec(8'hB4, 4'd1, 1'b1, 2'b11, 4'h9, 8'h5A);
        run_vec(8'h96, 4'd8, 1'b1, 2'b10, 4'hA, 8'h96);
        run_vec(8'h7F, 4'd8, 1'b1, 2'b01, 4'hB, 8'h00);
        run_vec(8'hB4, 4'd2, 1'b0, 2'b01, 4'hC, 8'hD0);

        // 16 back-to-back words, full throughput
        rdy = 1'b1;
        t0 = $time;
        for (int i = 0; i < 16; i++)
            send(W'($urandom), AW'($urandom), 1'($urandom), 2'($urandom), TW'(i), 1'b0);
        chk_eq("stream_cycles", 32'(($time - t0) / 10), 32'd16);
        drain();

        // backpressure: out_ready held low while offering words
        rdy = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data = 8'h11 * 8'(n_acc + 1); in_amt = AW'(n_acc + 1);
            in_dir = 1'b1; in_mode = 2'b10; in_tag = TW'(n_acc);
            #1;
            acc = in_ready1;
            @(posedge clk); #1;
            if (acc) n_acc++;
        end
        chk_eq("bp_accepted", 32'(n_acc), 32'd3);
        chk_eq("bp_in_ready", 32'(in_ready1), 32'd0);
        chk_eq("bp_out_valid", 32'(out_valid1), 32'd1);
        drain();

        // random out_ready over 1000 words with random gaps
        for (int i = 0; i < 1000; i++) begin
            send(W'($urandom), AW'($urandom), 1'($urandom), 2'($urandom), TW'(i), 1'b1);
            if ($urandom_range(0, 3) == 0) gap(1'b1);
        end
        drain();

        // reset with three words in flight (first parked at output)
        rdy = 1'b0;
        for (int i = 0; i < 3; i++)
            send(8'hC3 + 8'(i), 4'd1, 1'b0, 2'b00, TW'(i + 5), 1'b0);
        chk_eq("mid_out_valid_pre", 32'(out_valid1), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rdy = 1'b1;
        chk_eq("mid_rst_out_valid", 32'(out_valid1), 32'd0);
        chk_eq("mid_rst_out_valid_p0", 32'(out_valid0), 32'd0);
        chk_eq("mid_rst_out_data", 32'(out_data1), 32'd0);
        chk_eq("mid_rst_out_zero", 32'(out_zero1), 32'd1);
        chk_eq("mid_rst_in_ready", 32'(in_ready1), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk_eq("mid_rst_quiet", 32'(out_valid1), 32'd0);
        end
        for (int i = 0; i < 4; i++)
            send(W'($urandom), AW'($urandom), 1'($urandom), 2'($urandom), TW'(i + 10), 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
